// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (FSM encoding, parity modes, frame width).
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_START  = 5'b00010;
    localparam logic [4:0] S_DATA   = 5'b00100;
    localparam logic [4:0] S_PARITY = 5'b01000;
    localparam logic [4:0] S_STOP   = 5'b10000;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-frame bit timer; strobes bit_end every 2*div+1 cycles while enabled.
module uart_baud_tick (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] clock_div,
    output logic        bit_end
);

    logic [15:0] div_q;
    logic [16:0] cnt;

    assign bit_end = en && cnt == '0;

    // load latches the divisor so mid-frame clock_div changes wait for the next frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_q <= clock_div;
            cnt   <= {clock_div, 1'b0};
        end else if (bit_end) begin
            cnt   <= {div_q, 1'b0};
        end else if (en) begin
            cnt   <= cnt - 17'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8E1/8O1 (1 or 2 stop) serial transmitter with a one-deep holding register.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] clock_div,
    input  logic [7:0]  tx_data,
    input  logic        tx_start,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx
);

    localparam int PAR_MODE = (PARITY == PAR_ODD || PARITY == PAR_EVEN) ? PARITY : PAR_NONE;
    localparam bit PAR_EN   = PAR_MODE != PAR_NONE;
    localparam bit TWO_STOP = STOP_BITS == 2;

    logic [4:0]           st;
    logic [DATA_BITS-1:0] hold, sh;
    logic [2:0]           idx;
    logic                 hold_full, par_q, stop_cnt, bit_end;
    logic                 load, last_stop, frame_end, launch, line;

    assign tx_ready  = !hold_full;
    assign load      = tx_start && !hold_full;
    assign last_stop = !TWO_STOP || stop_cnt;
    assign frame_end = st == S_STOP && bit_end && last_stop;
    assign launch    = hold_full && (st == S_IDLE || frame_end);
    assign line      = st == S_START  ? 1'b0 :
                       st == S_DATA   ? sh[0] :
                       st == S_PARITY ? par_q : 1'b1;

    uart_baud_tick u_tick (
        .clock     (clock),
        .reset     (reset),
        .en        (st != S_IDLE),
        .load      (launch),
        .clock_div (clock_div),
        .bit_end   (bit_end)
    );

    // line and status are registered from the state, so they trail it by one cycle together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sh        <= '0;
            idx       <= '0;
            par_q     <= 1'b0;
            stop_cnt  <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            hold_full <= load || (hold_full && !launch);
            if (load)
                hold <= tx_data;
            if (launch) begin
                sh       <= hold;
                par_q    <= parity_bit(hold, PAR_MODE);
                idx      <= '0;
                stop_cnt <= 1'b0;
                st       <= S_START;
            end else if (bit_end) begin
                case (st)
                    S_START:  st <= S_DATA;
                    S_DATA: begin
                        sh  <= sh >> 1;
                        idx <= idx + 3'd1;
                        if (idx == 3'(DATA_BITS - 1))
                            st <= PAR_EN ? S_PARITY : S_STOP;
                    end
                    S_PARITY: st <= S_STOP;
                    S_STOP: begin
                        if (last_stop)
                            st <= S_IDLE;
                        else
                            stop_cnt <= 1'b1;
                    end
                    default:  st <= S_IDLE;
                endcase
            end
            tx      <= line;
            tx_busy <= st != S_IDLE;
            tx_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives five uart_tx configurations and checks tx/busy/done cycle by cycle
// against a waveform built from the framing rules.
module tb_uart_tx;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } samp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] clock_div = 16'd4;
    logic [7:0]  tx_data = 8'h00;
    logic [4:0]  start_v = '0;
    logic [4:0]  ready_v, busy_v, done_v, tx_v;

    int    tests = 0, fails = 0, errs = 0, cyc = 0, first_cyc = 0;
    int    k, d, r;
    logic [7:0] b1, b2;
    samp_t exp_q[$];
    samp_t first_o, first_e;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        uart_tx #(
            .PARITY    (g == 1 ? 1 : g == 2 ? 2 : g == 4 ? 3 : 0),
            .STOP_BITS (g == 3 ? 2 : g == 4 ? 3 : 1)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .clock_div (clock_div),
            .tx_data   (tx_data),
            .tx_start  (start_v[g]),
            .tx_ready  (ready_v[g]),
            .tx_busy   (busy_v[g]),
            .tx_done   (done_v[g]),
            .tx        (tx_v[g])
        );
    end

    function automatic int par_of(int n);
        return n == 1 ? 1 : n == 2 ? 2 : n == 4 ? 3 : 0;
    endfunction

    function automatic int stop_of(int n);
        return n == 3 ? 2 : n == 4 ? 3 : 1;
    endfunction

    // Frame = start 0, data LSB first, optional parity, stop 1s; each bit 2*div+1 cycles.
    task automatic add_frame(input logic [7:0] b, input int dv, input int par, input int stops);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (par == 1 || par == 2) bits.push_back((^b) ^ (par == 1));
        repeat (stops == 2 ? 2 : 1) bits.push_back(1'b1);
        foreach (bits[i])
            for (int c = 0; c < 2 * dv + 1; c++)
                exp_q.push_back(samp_t'({bits[i], 1'b1, (i == bits.size() - 1) && (c == 2 * dv)}));
    endtask

    task automatic add_idle(input int n);
        repeat (n) exp_q.push_back(samp_t'(3'b100));
    endtask

    task automatic load(input int n, input logic [7:0] b);
        tx_data = b;
        start_v[n] = 1'b1;
        @(posedge clock);
        #1;
        start_v[n] = 1'b0;
    endtask

    task automatic send(input int n, input logic [7:0] b, input int dv);
        clock_div = 16'(dv);
        load(n, b);
        add_idle(2);
        add_frame(b, dv, par_of(n), stop_of(n));
    endtask

    task automatic run(input int n, input int cycles);
        samp_t e, o;
        repeat (cycles) begin
            @(negedge clock);
            e = exp_q.size() > 0 ? exp_q.pop_front() : samp_t'(3'b100);
            o = {tx_v[n], busy_v[n], done_v[n]};
            if (o !== e) begin
                if (errs == 0) begin
                    first_cyc = cyc;
                    first_o = o;
                    first_e = e;
                end
                errs++;
            end
            cyc++;
        end
    endtask

    task automatic verdict(input string tag);
        tests++;
        assert (errs === 0) else begin
            fails++;
            $error("FAIL %s: %0d bad cycles, first at cycle %0d got tx/busy/done=%b required %b",
                   tag, errs, first_cyc, first_o, first_e);
        end
        errs = 0;
        cyc = 0;
    endtask

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %b required %b", tag, got, want);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_tx", tx_v, 5'h1f);
        chk("reset_busy", busy_v, 5'h00);
        chk("reset_ready", ready_v, 5'h1f);
        chk("reset_done", done_v, 5'h00);
        reset = 1'b0;
        @(negedge clock);

        send(0, 8'h55, 4);
        run(0, exp_q.size() + 2);
        verdict("frame_55_div4");
        chk("idle_after_55", busy_v, 5'h00);

        send(2, 8'h07, 1);
        run(2, exp_q.size() + 2);
        verdict("even_parity_07");

        send(1, 8'h07, 1);
        run(1, exp_q.size() + 2);
        verdict("odd_parity_07");

        send(4, 8'h5A, 1);
        run(4, exp_q.size() + 2);
        verdict("bad_params_as_8n1");

        send(3, 8'hA3, 1);
        run(3, 10);
        chk("b2b_ready_after_launch", ready_v[3], 5'd1);
        load(3, 8'h3C);
        r = exp_q.size();
        add_frame(8'h3C, 1, 0, 2);
        run(3, 3);
        chk("b2b_ready_held", ready_v[3], 5'd0);
        load(3, 8'hFF);
        run(3, r - 4);
        chk("b2b_ready_before_launch", ready_v[3], 5'd0);
        run(3, 1);
        chk("b2b_ready_at_launch", ready_v[3], 5'd1);
        run(3, exp_q.size() + 2);
        verdict("b2b_A3_3C_two_stop");

        send(0, 8'hC6, 4);
        run(0, 20);
        clock_div = 16'd10;
        load(0, 8'h39);
        add_frame(8'h39, 10, 0, 1);
        run(0, exp_q.size() + 2);
        verdict("div_change_mid_frame");

        send(0, 8'hF0, 4);
        run(0, 42);
        verdict("pre_reset_frame");
        reset = 1'b1;
        #1;
        chk("reset_mid_tx", tx_v, 5'h1f);
        chk("reset_mid_busy", busy_v, 5'h00);
        chk("reset_mid_ready", ready_v, 5'h1f);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        send(0, 8'h81, 4);
        run(0, exp_q.size() + 2);
        verdict("post_reset_81");

        for (int i = 0; i < 120; i++) begin
            k  = int'($urandom_range(0, 4));
            d  = int'($urandom_range(0, 3));
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            send(k, b1, d);
            run(k, 2);
            load(k, b2);
            add_frame(b2, d, par_of(k), stop_of(k));
            run(k, exp_q.size() + 2);
            verdict($sformatf("random_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
